// File: rtl/carry_skip_pkg.sv
// Shared constants and types for the carry-skip adder.
package carry_skip_pkg;

  localparam int unsigned CSA_WIDTH_DEFAULT = 32;
  localparam int unsigned CSA_BLOCK_DEFAULT = 4;

  // Full sum at the default width, including the carry-out bit.
  typedef logic [CSA_WIDTH_DEFAULT:0] csa_sum_t;

endpackage

// File: rtl/csa_skip_block.sv
// One ripple block of the carry-skip adder: ripple carries for the sum bits, plus a
// bypass mux that forwards the block carry-in when every bit propagates.
module csa_skip_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic             ripple_co;

  assign p = a ^ b;
  assign g = a & b;

  // Carry kept in a procedural variable so the chain is evaluated in order.
  always_comb begin : ripple
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]  = p[i] ^ carry;
      carry = g[i] | (p[i] & carry);
    end
    ripple_co = carry;
  end

  assign co = (&p) ? ci : ripple_co;

endmodule

// File: rtl/carry_skip_adder.sv
// Registered WIDTH-bit carry-skip adder, s = a + b + cin, latency 1.
// Define CARRY_SKIP_INPUT_REG_EN to also register a/b/cin (latency 2).
module carry_skip_adder
  import carry_skip_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH_DEFAULT,
  parameter int unsigned BLOCK = CSA_BLOCK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   s,
  output logic             cout
);

  localparam int unsigned NumBlocks = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : gen_cfg_err
    $error("carry_skip_adder: WIDTH must be a multiple of BLOCK");
  end

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef CARRY_SKIP_INPUT_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;

  always_comb begin
    a_d   = a;
    b_d   = b;
    cin_d = cin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  logic [WIDTH-1:0] sum_bits;
  logic             carry_out;

  // Each block takes its carry-in straight from the previous block's skip mux.
  for (genvar j = 0; j < NumBlocks; j++) begin : gen_blk
    logic blk_ci;
    logic blk_co;

    if (j == 0) begin : gen_first
      assign blk_ci = op_cin;
    end else begin : gen_rest
      assign blk_ci = gen_blk[j-1].blk_co;
    end

    csa_skip_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a (op_a[j*BLOCK +: BLOCK]),
      .b (op_b[j*BLOCK +: BLOCK]),
      .ci(blk_ci),
      .s (sum_bits[j*BLOCK +: BLOCK]),
      .co(blk_co)
    );
  end

  assign carry_out = gen_blk[NumBlocks-1].blk_co;

  logic [WIDTH:0] s_q, s_d;

  always_comb begin
    s_d = {carry_out, sum_bits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s    = s_q;
  assign cout = s_q[WIDTH];

endmodule

// File: tb/tb_carry_skip_adder.sv
// Self-checking bench for carry_skip_adder; follows CARRY_SKIP_INPUT_REG_EN for latency.
module tb_carry_skip_adder;
  import carry_skip_pkg::*;

  localparam int W = 32;
`ifdef CARRY_SKIP_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  csa_sum_t     s;
  logic         cout;

  int n_cmp = 0;
  int n_err = 0;
  csa_sum_t pipe[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    csa_sum_t     exp;
  } vec_t;

  vec_t vecs[10];

  carry_skip_adder #(
    .WIDTH(W),
    .BLOCK(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .s   (s),
    .cout(cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic csa_sum_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
    return csa_sum_t'(x) + csa_sum_t'(y) + csa_sum_t'(c);
  endfunction

  task automatic check(input string name, input csa_sum_t exp_s);
    n_cmp++;
    if (s !== exp_s || cout !== exp_s[W]) begin
      n_err++;
      $display("FAIL %s: got s=%h cout=%b, required s=%h cout=%b", name, s, cout, exp_s,
               exp_s[W]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One back-to-back cycle: drive, advance, compare against the result due now.
  task automatic stream_cycle(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                              input string name);
    csa_sum_t e;
    a   = x;
    b   = y;
    cin = c;
    pipe.push_back(model(x, y, c));
    tick();
    if (pipe.size() >= LAT) begin
      e = pipe.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    a   = 32'h1234_5678;
    b   = 32'h0F0F_0F0F;
    cin = 1'b1;

    vecs[0] = '{32'd41,        32'd3,         1'b1, 33'h0_0000_002D};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0,         1'b1, 33'h1_0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
    vecs[3] = '{32'h0000_000F, 32'h1,         1'b0, 33'h0_0000_0010};
    vecs[4] = '{32'h0,         32'h0,         1'b0, 33'h0_0000_0000};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
    vecs[6] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 33'h1_0000_0000};
    vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789};
    vecs[8] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 33'h0_0001_0000};
    vecs[9] = '{32'hFFFF_FFFF, 32'h0,         1'b0, 33'h0_FFFF_FFFF};

    // Async clear before any clock edge has occurred.
    #3 rst = 1'b1;
    #1 check("reset_async_initial", '0);
    tick();
    tick();
    check("reset_held", '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      repeat (LAT) tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Output must clear mid-cycle on rst, without a clock edge.
    a   = 32'hFFFF_FFFF;
    b   = 32'hFFFF_FFFF;
    cin = 1'b1;
    repeat (LAT) tick();
    check("pre_async", 33'h1_FFFF_FFFF);
    #2 rst = 1'b1;
    #1 check("reset_async_mid", '0);
    tick();
    check("reset_async_edge", '0);
    rst = 1'b0;
    repeat (LAT) tick();
    check("after_release", 33'h1_FFFF_FFFF);

    // Back-to-back stream with a reset pulse in the middle.
    pipe.delete();
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        rst = 1'b1;
        #1 check("stream_rst_async", '0);
        a = $urandom();
        tick();
        check("stream_rst_edge", '0);
        tick();
        check("stream_rst_edge2", '0);
        rst = 1'b0;
        pipe.delete();
      end
      stream_cycle($urandom(), $urandom(), 1'($urandom_range(1)), "stream");
    end

    // Randomized, back-to-back, including occasional all-propagate patterns.
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = $urandom();
      y = $urandom();
      if ($urandom_range(7) == 0) y = ~x;
      stream_cycle(x, y, 1'($urandom_range(1)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
